mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous word RAM between three requesters: core instruction fetch (IF), core data access (DM) and the external debug/loader port (DBG).
- Sits between the core's MMU-side interface and the on-chip RAM macro.
- Performs fixed-priority arbitration with an IF anti-starvation guard.
- Aligns and sign-extends DM read data, checks DM byte-enable/address alignment, and generates the core stall.

---
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF / DM / DBG onto one single-port synchronous RAM and formats
// the DM load data. IF gets one guaranteed slot after IF_MAX_WAIT denials.
module mem_port_arbiter #(
    parameter int ADDR_W      = 12,
    parameter int IF_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [3:0]        dm_be,
    input  logic              dm_is_signed,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_gnt,
    output logic              dm_err,
    output logic              dm_rvalid,
    output logic [31:0]       dm_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [31:0]       dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [31:0]       dbg_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              core_stall
);

    localparam logic [2:0] MAX_WAIT = 3'(IF_MAX_WAIT);

    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM, OWN_DBG} owner_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    typedef struct packed {
        owner_t     owner;
        logic [1:0] off;
        size_t      size;
        logic       sgn;
    } tag_t;

    logic [2:0] starve_cnt;
    logic       if_prio;
    logic       dm_ok;
    size_t      dm_size;
    logic       dbg_win, dm_win, if_win;
    tag_t       tag, nxt_tag;
    logic [31:0] dm_sh;

    logic unused_bits;
    assign unused_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                           dm_addr[31:ADDR_W+2],
                           dbg_addr[31:ADDR_W+2], dbg_addr[1:0]};

    // Only naturally aligned byte/half/word lane masks are legal.
    always_comb begin
        dm_ok   = 1'b0;
        dm_size = SZ_BYTE;
        case ({dm_be, dm_addr[1:0]})
            6'b0001_00, 6'b0010_01, 6'b0100_10, 6'b1000_11: dm_ok = 1'b1;
            6'b0011_00, 6'b1100_10: begin dm_ok = 1'b1; dm_size = SZ_HALF; end
            6'b1111_00:             begin dm_ok = 1'b1; dm_size = SZ_WORD; end
            default:                dm_ok = 1'b0;
        endcase
    end

    assign if_prio = (starve_cnt == MAX_WAIT);
    assign dbg_win = resetb & dbg_req;
    assign if_win  = resetb & ~dbg_req & if_req & (if_prio | ~dm_req);
    assign dm_win  = resetb & ~dbg_req & dm_req & ~(if_prio & if_req);

    assign dbg_gnt    = dbg_win;
    assign if_gnt     = if_win;
    assign dm_gnt     = dm_win;
    assign dm_err     = dm_win & ~dm_ok;
    assign core_stall = (if_req & ~if_gnt) | (dm_req & ~dm_gnt);

    // An errored DM grant still owns the slot, so IF cannot fall into it.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        nxt_tag   = '0;
        if (dbg_win) begin
            mem_en    = 1'b1;
            mem_we    = dbg_we ? 4'b1111 : 4'b0000;
            mem_addr  = dbg_addr[ADDR_W+1:2];
            mem_wdata = dbg_wdata;
            if (!dbg_we) begin
                nxt_tag.owner = OWN_DBG;
                nxt_tag.size  = SZ_WORD;
            end
        end else if (dm_win && dm_ok) begin
            mem_en    = 1'b1;
            mem_we    = dm_we ? dm_be : 4'b0000;
            mem_addr  = dm_addr[ADDR_W+1:2];
            mem_wdata = dm_wdata;
            if (!dm_we) begin
                nxt_tag.owner = OWN_DM;
                nxt_tag.off   = dm_addr[1:0];
                nxt_tag.size  = dm_size;
                nxt_tag.sgn   = dm_is_signed;
            end
        end else if (if_win) begin
            mem_en   = 1'b1;
            mem_addr = if_addr[ADDR_W+1:2];
            nxt_tag.owner = OWN_IF;
            nxt_tag.size  = SZ_WORD;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            tag        <= '0;
            starve_cnt <= 3'd0;
        end else begin
            tag <= nxt_tag;
            if (!if_req || if_gnt)
                starve_cnt <= 3'd0;
            else if (starve_cnt != MAX_WAIT)
                starve_cnt <= starve_cnt + 3'd1;
        end
    end

    assign if_rvalid  = (tag.owner == OWN_IF);
    assign dm_rvalid  = (tag.owner == OWN_DM);
    assign dbg_rvalid = (tag.owner == OWN_DBG);
    assign if_rdata   = mem_rdata;
    assign dbg_rdata  = mem_rdata;

    assign dm_sh = mem_rdata >> {tag.off, 3'b000};

    always_comb begin
        case (tag.size)
            SZ_BYTE: dm_rdata = {{24{tag.sgn & dm_sh[7]}},  dm_sh[7:0]};
            SZ_HALF: dm_rdata = {{16{tag.sgn & dm_sh[15]}}, dm_sh[15:0]};
            default: dm_rdata = dm_sh;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous RAM.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 12;

    logic clk = 1'b0;
    logic resetb;
    logic if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic dm_req, dm_we, dm_is_signed, dm_gnt, dm_err, dm_rvalid;
    logic [3:0] dm_be;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic mem_en;
    logic [3:0] mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic core_stall;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .IF_MAX_WAIT(4)) dut (
        .clk(clk), .resetb(resetb),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_is_signed(dm_is_signed),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_err(dm_err),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .core_stall(core_stall)
    );

    logic [31:0] ram [0:(1<<ADDR_W)-1];

    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req = 0; dm_req = 0; dbg_req = 0;
        dm_we = 0; dbg_we = 0;
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [3:0]  be;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        e_err;
        logic        e_en;
        logic [3:0]  e_we;
        logic [ADDR_W-1:0] e_maddr;
        logic        e_rvalid;
        logic [31:0] e_rdata;
    } dm_vec_t;

    dm_vec_t vecs [11];

    initial begin
        vecs[0]  = '{"ldb_s_103",  0, 4'b1000, 1, 32'h103, 32'h0,        0, 1, 4'b0000, 12'h040, 1, 32'hFFFFFF80};
        vecs[1]  = '{"ldb_u_103",  0, 4'b1000, 0, 32'h103, 32'h0,        0, 1, 4'b0000, 12'h040, 1, 32'h00000080};
        vecs[2]  = '{"ldb_s_100",  0, 4'b0001, 1, 32'h100, 32'h0,        0, 1, 4'b0000, 12'h040, 1, 32'hFFFFFFFF};
        vecs[3]  = '{"ldh_s_104",  0, 4'b0011, 1, 32'h104, 32'h0,        0, 1, 4'b0000, 12'h041, 1, 32'hFFFF8765};
        vecs[4]  = '{"ldh_u_106",  0, 4'b1100, 0, 32'h106, 32'h0,        0, 1, 4'b0000, 12'h041, 1, 32'h00001234};
        vecs[5]  = '{"ldw_104",    0, 4'b1111, 1, 32'h104, 32'h0,        0, 1, 4'b0000, 12'h041, 1, 32'h12348765};
        vecs[6]  = '{"sth_002",    1, 4'b1100, 0, 32'h002, 32'hBEEF0000, 0, 1, 4'b1100, 12'h000, 0, 32'h0};
        vecs[7]  = '{"ldw_000",    0, 4'b1111, 0, 32'h000, 32'h0,        0, 1, 4'b0000, 12'h000, 1, 32'hBEEF0013};
        vecs[8]  = '{"err_0011_1", 0, 4'b0011, 0, 32'h001, 32'h0,        1, 0, 4'b0000, 12'h000, 0, 32'h0};
        vecs[9]  = '{"err_0000_0", 0, 4'b0000, 0, 32'h000, 32'h0,        1, 0, 4'b0000, 12'h000, 0, 32'h0};
        vecs[10] = '{"err_1111_2", 1, 4'b1111, 0, 32'h002, 32'h0,        1, 0, 4'b0000, 12'h000, 0, 32'h0};

        for (int i = 0; i < (1<<ADDR_W); i++) ram[i] = 32'h0;
        ram[12'h000] = 32'h00000013;
        ram[12'h040] = 32'h80FFFFFF;
        ram[12'h041] = 32'h12348765;

        // Reset with every requester active: nothing may be granted.
        resetb = 0;
        if_req = 1; dm_req = 1; dbg_req = 1;
        if_addr = 0; dm_addr = 0; dm_be = 4'b1111; dm_we = 1; dm_is_signed = 0;
        dm_wdata = 32'hFFFFFFFF; dbg_we = 1; dbg_addr = 0; dbg_wdata = 32'hFFFFFFFF;
        #3;
        chk("rst_gnts", {dbg_gnt, dm_gnt, if_gnt, dm_err}, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        cyc(); cyc();
        chk("rst_rvalid", {if_rvalid, dm_rvalid, dbg_rvalid}, 0);
        idle();
        #2 resetb = 1;
        cyc();

        // First fetch.
        if_req = 1; if_addr = 32'h0;
        #1 chk("if_gnt", if_gnt, 1);
        chk("if_mem_addr", mem_addr, 0);
        chk("if_stall", core_stall, 0);
        cyc();
        idle();
        chk("if_rvalid", if_rvalid, 1);
        chk("if_rdata", if_rdata, 32'h00000013);
        cyc();
        chk("if_rvalid_drop", if_rvalid, 0);

        foreach (vecs[i]) begin
            dm_req = 1; dm_we = vecs[i].we; dm_be = vecs[i].be;
            dm_is_signed = vecs[i].sgn; dm_addr = vecs[i].addr; dm_wdata = vecs[i].wdata;
            #1;
            chk({vecs[i].name, "_gnt"}, dm_gnt, 1);
            chk({vecs[i].name, "_err"}, dm_err, vecs[i].e_err);
            chk({vecs[i].name, "_en"},  mem_en, vecs[i].e_en);
            chk({vecs[i].name, "_we"},  mem_we, vecs[i].e_we);
            if (vecs[i].e_en) chk({vecs[i].name, "_maddr"}, mem_addr, vecs[i].e_maddr);
            cyc();
            idle();
            chk({vecs[i].name, "_rvalid"}, dm_rvalid, vecs[i].e_rvalid);
            if (vecs[i].e_rvalid) chk({vecs[i].name, "_rdata"}, dm_rdata, vecs[i].e_rdata);
            cyc();
        end

        // IF starves behind DM for four cycles, then takes one slot.
        if_req = 1; if_addr = 32'h0;
        dm_req = 1; dm_we = 0; dm_be = 4'b1111; dm_addr = 32'h104; dm_is_signed = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("starve_dm_gnt%0d", i), dm_gnt, (i < 4) ? 1 : 0);
            chk($sformatf("starve_if_gnt%0d", i), if_gnt, (i == 4) ? 1 : 0);
            chk($sformatf("starve_stall%0d", i), core_stall, 1);
            cyc();
        end
        chk("starve_if_rvalid", if_rvalid, 1);
        chk("starve_if_rdata", if_rdata, 32'hBEEF0013);
        #1 chk("starve_cnt_clr_dm", dm_gnt, 1);
        chk("starve_cnt_clr_if", if_gnt, 0);
        cyc();

        // DBG beats both, even while the guard is saturated.
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("dbg_win_gnt%0d", i), {dbg_gnt, dm_gnt, if_gnt}, 3'b100);
            chk($sformatf("dbg_win_stall%0d", i), core_stall, 1);
            cyc();
        end
        dbg_req = 0;
        #1 chk("sat_if_gnt", if_gnt, 1);
        chk("sat_dm_gnt", dm_gnt, 0);
        cyc();
        idle();
        cyc(); cyc();

        // DBG read granted, reset hits before its response: the read is dropped.
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h100;
        #1 chk("dbgrd_gnt", dbg_gnt, 1);
        @(posedge clk);
        resetb = 0;
        idle();
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dbgrd_rst_rvalid%0d", i), dbg_rvalid, 0);
            if (i == 1) resetb = 1;
            cyc();
        end

        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h100; dbg_wdata = 32'hCAFEF00D;
        #1 chk("dbgwr_gnt", dbg_gnt, 1);
        chk("dbgwr_we", mem_we, 4'b1111);
        chk("dbgwr_maddr", mem_addr, 12'h040);
        cyc();
        dbg_we = 0;
        chk("dbgwr_rvalid", dbg_rvalid, 0);
        cyc();
        idle();
        chk("dbgrd2_rvalid", dbg_rvalid, 1);
        chk("dbgrd2_rdata", dbg_rdata, 32'hCAFEF00D);
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
